pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline (IF,ID,EX,MEM,WB); successor to the fixed-function hazard unit.
//  Adds N multi-cycle EX units (div, mul, ...) with a per-unit start/busy/done FSM and single-cycle start pulses.
//  Adds cancel on exception, a configurable exception vector and a wrapping stall-cycle counter.
//  Sits beside the datapath; all pipeline-register stall/flush enables come from here.
// PARAMETERS
//  N_MC       2             number of multi-cycle EX units (index 0 = div, 1 = mul)
//  REG_W      5             register-index width
//  EXC_VECTOR 32'hBFC00380  redirect PC for every non-ERET exception
//  ERET_CODE  32'h0000000E  excepttype value meaning ERET (redirect to EPC)
//  CNT_W      32            stall-cycle counter width
// PORTS
//  clk             in   1      rising-edge clock
//  resetn          in   1      synchronous, active-low reset
//  id_rs, id_rt    in   REG_W  source registers of the instruction in ID
//  ex_rt           in   REG_W  destination of the instruction in EX
//  ex_rmem         in   1      instruction in EX is a load
//  ex_mc_req       in   N_MC   EX instruction needs unit i (one-hot or zero)
//  mc_ready        in   N_MC   unit i result valid (level, held until next start)
//  mc_start        out  N_MC   one-cycle start pulse to unit i
//  mc_cancel       out  N_MC   one-cycle abort to unit i
//  stallreq_from_if   in  1    instruction fetch not ready
//  stallreq_from_mem  in  1    data access not ready
//  mem_excepttype  in   32     nonzero = exception in MEM
//  mem_cp0_epc     in   32     EPC for ERET
//  stall           out  5      per-stage hold, bit0=IF .. bit4=WB
//  flush           out  5      per-stage bubble insert, same indexing
//  mem_newpc       out  32     redirect target, valid when flush[0]
//  stall_cycles    out  CNT_W  cycles with stall[0]=1 since reset
// BEHAVIOUR
//  Reset (resetn=0 at posedge): all FSMs IDLE, stall_cycles=0. While resetn=0, flush=5'b11111,
//   stall=0, mc_start=0, mc_cancel=0, mem_newpc=0.
//  exc = (mem_excepttype!=0). exc_fire = exc & ~stallreq_from_mem; the exception waits while the bus is busy.
//  Load-use: lu = ex_rmem & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//  Per-unit FSM i: IDLE -> BUSY when ex_mc_req[i] & ~exc_fire & ~stallreq_from_mem; mc_start[i]=1 that cycle only.
//   BUSY -> DONE when mc_ready[i]. DONE -> IDLE when stall[2]=0, i.e. when EX advances.
//   Any state with exc_fire -> IDLE; mc_cancel[i]=1 if the state was BUSY.
//  mcs = OR_i[(IDLE & ex_mc_req[i]) | BUSY]. DONE does not stall, so the result is consumed exactly once.
//  stall[1:0] = lu | mcs | stallreq_from_if | stallreq_from_mem; stall[3:2] = mcs | stallreq_from_mem; stall[4]=0.
//  exc_fire overrides: when it is 1, stall=0 and flush=5'b11111.
//  Otherwise flush[2]=lu & ~mcs & ~stallreq_from_mem, flush[4]=stallreq_from_mem, and the other flush bits are 0.
//  mem_newpc: ERET_CODE -> mem_cp0_epc; any other nonzero code -> EXC_VECTOR; 0 -> 32'h0. Combinational, never latched.
//  stall_cycles += 1 each cycle stall[0]=1 and resetn=1; wraps at 2^CNT_W-1 -> 0.
//  Simultaneous ex_mc_req and lu: both stall; the bubble is withheld until mcs clears.
//  Reset mid-operation: BUSY unit returns to IDLE; no mc_cancel is issued because the unit is reset too.
// STRUCTURE
//  Shared package (cpu_pkg): MC_DIV/MC_MUL indices, stage indices IF..WB, excepttype codes, EXC_VECTOR default.
//  Sub-module mc_tracker: one FSM per unit, instantiated N_MC times via generate.
//   Interface: req, ready, fire, ex_adv -> start, cancel, stall_out.
// TESTING
//  Load-use: ex_rmem=1, ex_rt=5, id_rs=5 -> stall=5'b00011, flush=5'b00100 for one cycle. With ex_rt=0 -> no stall.
//  Divide: ex_mc_req=01, mc_ready rises after 33 cycles -> mc_start pulses once and stall[3:0]=1 for 34 cycles.
//   Then DONE, stall drops, and there is no second start.
//  Exception while BUSY: mem_excepttype=0x4 -> mc_cancel[0]=1, flush=11111, mem_newpc=BFC00380, FSM returns to IDLE.
//  ERET deferred: excepttype=0xE while stallreq_from_mem=1 for 3 cycles -> no flush for those 3 cycles.
//   Then one cycle of flush=11111 with mem_newpc=mem_cp0_epc.
//  Reset: resetn=0 mid-BUSY for 1 cycle -> flush=11111, stall_cycles=0, FSM IDLE.
//  Counter wrap (CNT_W=4): 17 stalled cycles -> stall_cycles=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, exception codes and multi-cycle unit state
package cpu_pkg;

  localparam int MC_DIV = 0;
  localparam int MC_MUL = 1;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [31:0] EXC_NONE           = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET           = 32'h0000_000E;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // ERET returns to EPC; every other nonzero code goes to the common vector.
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector,
                                             input logic [31:0] eret);
    if (code == EXC_NONE) return 32'h0000_0000;
    if (code == eret) return epc;
    return vector;
  endfunction

endpackage

// File: rtl/mc_tracker.sv
// rtl/mc_tracker.sv - start/busy/done tracking for one multi-cycle EX unit
module mc_tracker
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic ready,
  input  logic fire,
  input  logic mem_busy,
  input  logic ex_adv,
  output logic start,
  output logic cancel,
  output logic stall_out
);

  mc_state_e state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= MC_IDLE;
    end else if (fire) begin
      state_q <= MC_IDLE;
    end else begin
      case (state_q)
        MC_IDLE: if (req && !mem_busy) state_q <= MC_BUSY;
        MC_BUSY: if (ready) state_q <= MC_DONE;
        MC_DONE: if (ex_adv) state_q <= MC_IDLE;
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  // Start must coincide with the IDLE->BUSY edge, so it is decoded from the current state.
  assign start     = resetn && (state_q == MC_IDLE) && req && !fire && !mem_busy;
  assign cancel    = resetn && (state_q == MC_BUSY) && fire;
  assign stall_out = ((state_q == MC_IDLE) && req) || (state_q == MC_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int          N_MC       = 2,
  parameter int          REG_W      = 5,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] ERET_CODE  = EXC_ERET,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_rmem,
  input  logic [N_MC-1:0]  ex_mc_req,
  input  logic [N_MC-1:0]  mc_ready,
  output logic [N_MC-1:0]  mc_start,
  output logic [N_MC-1:0]  mc_cancel,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      mem_excepttype,
  input  logic [31:0]      mem_cp0_epc,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic [31:0]      mem_newpc,
  output logic [CNT_W-1:0] stall_cycles
);

  logic            exc_fire;
  logic            lu;
  logic            mcs;
  logic            ex_adv;
  logic [N_MC-1:0] mc_stall;
  logic [CNT_W-1:0] stall_cycles_q;

  // An exception in MEM cannot be taken while the data bus is still busy.
  assign exc_fire = (mem_excepttype != EXC_NONE) && !stallreq_from_mem;
  assign lu       = ex_rmem && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign mcs      = |mc_stall;
  assign ex_adv   = !stall[STG_EX];

  for (genvar i = 0; i < N_MC; i++) begin : g_mc
    mc_tracker u_mc_tracker (
      .clk       (clk),
      .resetn    (resetn),
      .req       (ex_mc_req[i]),
      .ready     (mc_ready[i]),
      .fire      (exc_fire),
      .mem_busy  (stallreq_from_mem),
      .ex_adv    (ex_adv),
      .start     (mc_start[i]),
      .cancel    (mc_cancel[i]),
      .stall_out (mc_stall[i])
    );
  end

  always_comb begin
    stall = '0;
    flush = '0;
    if (!resetn || exc_fire) begin
      flush = '1;
    end else begin
      stall[STG_IF]  = lu || mcs || stallreq_from_if || stallreq_from_mem;
      stall[STG_ID]  = lu || mcs || stallreq_from_if || stallreq_from_mem;
      stall[STG_EX]  = mcs || stallreq_from_mem;
      stall[STG_MEM] = mcs || stallreq_from_mem;
      // The load-use bubble waits until nothing downstream of ID is holding.
      flush[STG_EX]  = lu && !mcs && !stallreq_from_mem;
      flush[STG_WB]  = stallreq_from_mem;
    end
  end

  assign mem_newpc = resetn ? exc_target(mem_excepttype, mem_cp0_epc, EXC_VECTOR, ERET_CODE)
                            : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles_q <= '0;
    end else if (stall[STG_IF]) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] ERET = 32'h0000_000E;
  localparam int          CW   = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          ex_rmem;
  logic [1:0]    ex_mc_req, mc_ready, mc_start, mc_cancel;
  logic          stallreq_from_if, stallreq_from_mem;
  logic [31:0]   mem_excepttype, mem_cp0_epc;
  logic [4:0]    stall, flush;
  logic [31:0]   mem_newpc;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model state: per unit "operation in flight" and "result waiting to be consumed".
  bit m_busy[2];
  bit m_done[2];
  int m_cnt = 0;

  logic [4:0]  last_stall, last_flush;
  logic [1:0]  last_start, last_cancel;
  logic [31:0] last_pc;
  logic [CW-1:0] last_cnt;

  pipeline_ctrl #(.N_MC(2), .REG_W(5), .EXC_VECTOR(VEC), .ERET_CODE(ERET), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_rmem(ex_rmem), .ex_mc_req(ex_mc_req), .mc_ready(mc_ready),
    .mc_start(mc_start), .mc_cancel(mc_cancel),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc),
    .stall(stall), .flush(flush), .mem_newpc(mem_newpc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs applied; checks against the model, then advances one cycle.
  task automatic cycle();
    logic fire, lu_m, mcs_m;
    logic [4:0] es, ef;
    logic [31:0] epc;
    logic [1:0] est, ecn;
    #1;
    fire  = resetn && (mem_excepttype != 0) && !stallreq_from_mem;
    lu_m  = ex_rmem && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    mcs_m = 1'b0;
    est = 2'b00;
    ecn = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] || (!m_done[i] && ex_mc_req[i])) mcs_m = 1'b1;
      if (resetn && !m_busy[i] && !m_done[i] && ex_mc_req[i] && !fire && !stallreq_from_mem) est[i] = 1'b1;
      if (resetn && m_busy[i] && fire) ecn[i] = 1'b1;
    end
    if (!resetn || fire) begin
      es = 5'b00000;
      ef = 5'b11111;
    end else begin
      es = {1'b0, {2{mcs_m || stallreq_from_mem}},
            {2{lu_m || mcs_m || stallreq_from_if || stallreq_from_mem}}};
      ef = {stallreq_from_mem, 1'b0, lu_m && !mcs_m && !stallreq_from_mem, 2'b00};
    end
    if (!resetn || mem_excepttype == 0) epc = 32'h0;
    else if (mem_excepttype == ERET) epc = mem_cp0_epc;
    else epc = VEC;

    last_stall = stall; last_flush = flush; last_start = mc_start;
    last_cancel = mc_cancel; last_pc = mem_newpc; last_cnt = stall_cycles;
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("mem_newpc", mem_newpc, epc);
    chk("mc_start", 32'(mc_start), 32'(est));
    chk("mc_cancel", 32'(mc_cancel), 32'(ecn));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));

    if (!resetn) begin
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin m_busy[i] = 0; m_done[i] = 0; end
    end else begin
      if (es[0]) m_cnt = (m_cnt + 1) % (1 << CW);
      for (int i = 0; i < 2; i++) begin
        if (fire) begin m_busy[i] = 0; m_done[i] = 0; end
        else if (m_busy[i]) begin if (mc_ready[i]) begin m_busy[i] = 0; m_done[i] = 1; end end
        else if (m_done[i]) begin if (!es[2]) m_done[i] = 0; end
        else if (ex_mc_req[i] && !stallreq_from_mem) m_busy[i] = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_rmem = 0; ex_mc_req = 0; mc_ready = 0;
    stallreq_from_if = 0; stallreq_from_mem = 0; mem_excepttype = 0; mem_cp0_epc = 32'h8000_1234;
  endtask

  task automatic do_reset();
    quiet();
    resetn = 0;
    cycle();
    cycle();
    resetn = 1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, xrt;
    logic rmem, sif, smem;
    logic [31:0] exc;
    logic [4:0] e_stall, e_flush;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, rt, xrt, input logic rmem, sif, smem,
                              input logic [31:0] exc, input logic [4:0] es, ef,
                              input logic [31:0] pc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.xrt = xrt; v.rmem = rmem; v.sif = sif; v.smem = smem;
    v.exc = exc; v.e_stall = es; v.e_flush = ef; v.e_pc = pc;
    return v;
  endfunction

  initial begin
    vec_t tbl[11];
    int starts, stalls, full;
    tbl[0]  = mk(5, 0, 5, 1, 0, 0, 0,    5'b00011, 5'b00100, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 0,    5'b00000, 5'b00000, 0);
    tbl[2]  = mk(3, 7, 7, 1, 0, 0, 0,    5'b00011, 5'b00100, 0);
    tbl[3]  = mk(5, 0, 5, 0, 0, 0, 0,    5'b00000, 5'b00000, 0);
    tbl[4]  = mk(1, 2, 3, 0, 1, 0, 0,    5'b00011, 5'b00000, 0);
    tbl[5]  = mk(1, 2, 3, 0, 0, 1, 0,    5'b01111, 5'b10000, 0);
    tbl[6]  = mk(5, 0, 5, 1, 0, 1, 0,    5'b01111, 5'b10000, 0);
    tbl[7]  = mk(1, 2, 3, 0, 0, 0, 4,    5'b00000, 5'b11111, VEC);
    tbl[8]  = mk(1, 2, 3, 0, 0, 0, ERET, 5'b00000, 5'b11111, 32'h8000_1234);
    tbl[9]  = mk(1, 2, 3, 0, 0, 1, 4,    5'b01111, 5'b10000, VEC);
    tbl[10] = mk(5, 0, 5, 1, 1, 0, 4,    5'b00000, 5'b11111, VEC);

    quiet();
    resetn = 0;
    @(negedge clk);
    cycle();
    chk("reset_flush", 32'(last_flush), 32'h1F);
    chk("reset_stall", 32'(last_stall), 32'h0);
    chk("reset_pc", last_pc, 32'h0);
    resetn = 1;
    cycle();
    chk("reset_cnt", 32'(last_cnt), 32'h0);

    for (int k = 0; k < 11; k++) begin
      quiet();
      id_rs = tbl[k].rs; id_rt = tbl[k].rt; ex_rt = tbl[k].xrt; ex_rmem = tbl[k].rmem;
      stallreq_from_if = tbl[k].sif; stallreq_from_mem = tbl[k].smem; mem_excepttype = tbl[k].exc;
      cycle();
      chk($sformatf("vec%0d_stall", k), 32'(last_stall), 32'(tbl[k].e_stall));
      chk($sformatf("vec%0d_flush", k), 32'(last_flush), 32'(tbl[k].e_flush));
      chk($sformatf("vec%0d_pc", k), last_pc, tbl[k].e_pc);
    end

    // Divide: ready after 33 busy-side cycles -> 34 stalled cycles, one start.
    do_reset();
    ex_mc_req = 2'b01;
    starts = 0; stalls = 0; full = 0;
    for (int k = 0; k < 36; k++) begin
      mc_ready = (k >= 33) ? 2'b01 : 2'b00;
      if (k == 35) ex_mc_req = 2'b00;
      cycle();
      starts += int'(last_start[0]);
      stalls += int'(last_stall[0]);
      if (last_stall == 5'b01111) full++;
    end
    chk("div_starts", 32'(starts), 1);
    chk("div_stall_cycles", 32'(stalls), 34);
    chk("div_stall_3_0", 32'(full), 34);

    // Exception while BUSY cancels the divide.
    do_reset();
    ex_mc_req = 2'b01;
    for (int k = 0; k < 3; k++) cycle();
    mem_excepttype = 32'h4;
    cycle();
    chk("exc_cancel", 32'(last_cancel), 32'h1);
    chk("exc_flush", 32'(last_flush), 32'h1F);
    chk("exc_pc", last_pc, VEC);
    chk("exc_stall", 32'(last_stall), 32'h0);
    mem_excepttype = 0; ex_mc_req = 2'b00;
    cycle();
    ex_mc_req = 2'b01;
    cycle();
    chk("exc_idle_restart", 32'(last_start), 32'h1);

    // ERET held off by a busy data bus.
    do_reset();
    mem_excepttype = ERET; mem_cp0_epc = 32'h8000_0100; stallreq_from_mem = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("eret_wait%0d_flush", k), 32'(last_flush), 32'h10);
      chk($sformatf("eret_wait%0d_stall", k), 32'(last_stall), 32'h0F);
    end
    stallreq_from_mem = 0;
    cycle();
    chk("eret_flush", 32'(last_flush), 32'h1F);
    chk("eret_pc", last_pc, 32'h8000_0100);

    // Reset in the middle of a BUSY unit.
    do_reset();
    ex_mc_req = 2'b01;
    cycle();
    cycle();
    resetn = 0;
    cycle();
    chk("rst_busy_flush", 32'(last_flush), 32'h1F);
    chk("rst_busy_cancel", 32'(last_cancel), 32'h0);
    chk("rst_busy_start", 32'(last_start), 32'h0);
    resetn = 1;
    cycle();
    chk("rst_busy_cnt", 32'(last_cnt), 32'h0);
    chk("rst_busy_idle", 32'(last_start), 32'h1);

    // Counter wrap with a 4-bit counter.
    do_reset();
    stallreq_from_if = 1;
    for (int k = 0; k < 17; k++) cycle();
    stallreq_from_if = 0;
    cycle();
    chk("cnt_wrap", 32'(last_cnt), 32'h1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      resetn = ($urandom_range(0, 99) != 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_rmem = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: ex_mc_req = 2'b01;
        1: ex_mc_req = 2'b10;
        default: ex_mc_req = 2'b00;
      endcase
      mc_ready = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      stallreq_from_if = ($urandom_range(0, 4) == 0);
      stallreq_from_mem = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 15))
        0: mem_excepttype = 32'h4;
        1: mem_excepttype = ERET;
        2: mem_excepttype = $urandom;
        default: mem_excepttype = 0;
      endcase
      mem_cp0_epc = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
